// File: rtl/adder_timebase_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_timebase_if                                            |
// | Description : Bundles the operand/control inputs and the adder, carry and  |
// |               timebase outputs of adder_timebase.                          |
// |               master : drives a, b, cin, run_n, clear; observes results.   |
// |               slave  : the adder_timebase block itself.                    |
// |   a, b        WIDTH   operands                                             |
// |   cin         1       carry in                                             |
// |   run_n       1       0 = run prescaler, 1 = freeze                        |
// |   clear       1       synchronous clear of latch and counters              |
// |   sum         WIDTH   registered low bits of a+b+cin                       |
// |   carry       1       registered carry out                                 |
// |   carry_latch 1       sticky carry flag                                    |
// |   carry_cnt   CNT_W   saturating count of carry rising edges               |
// |   tick        1       one-cycle timebase pulse                             |
// |   tick_cnt    CNT_W   wrapping tick counter                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface adder_timebase_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             run_n;
  logic             clear;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             carry_latch;
  logic [CNT_W-1:0] carry_cnt;
  logic             tick;
  logic [CNT_W-1:0] tick_cnt;

  modport master (
    output a, b, cin, run_n, clear,
    input  sum, carry, carry_latch, carry_cnt, tick, tick_cnt
  );

  modport slave (
    input  a, b, cin, run_n, clear,
    output sum, carry, carry_latch, carry_cnt, tick, tick_cnt
  );
endinterface
`default_nettype wire

// File: rtl/adder_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_timebase                                               |
// | Description : Registered WIDTH-bit adder with carry-in, sticky carry latch,|
// |               saturating carry-edge counter, and a run/stop gated          |
// |               prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ    |
// |               cycles plus a wrapping tick counter.                         |
// | Ports       : clk      board clock, all logic on posedge                   |
// |               reset_n  asynchronous active-low reset                       |
// |               bus      adder_timebase_if.slave (operands, controls,        |
// |                        sum/carry, latch, counters, tick)                   |
// | Options     : INPUT_SYNC_EN - when defined, a, b, cin, run_n and clear     |
// |               pass through a 2-flop synchroniser (adds 2 cycles latency).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module adder_timebase #(
  parameter int WIDTH   = 4,
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 2,
  parameter int CNT_W   = 2
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  adder_timebase_if.slave bus
);

  localparam int c_div  = CLK_HZ / TICK_HZ;
  localparam int c_pw   = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_in_w = 2 * WIDTH + 3;
  localparam logic [c_pw-1:0]  c_pmax = c_pw'(c_div - 1);
  localparam logic [CNT_W-1:0] c_cmax = '1;

  // Inputs packed as {a, b, cin, run_n, clear}
  logic [c_in_w-1:0] w_raw;
  logic [c_in_w-1:0] w_in;

  assign w_raw = {bus.a, bus.b, bus.cin, bus.run_n, bus.clear};

`ifdef INPUT_SYNC_EN
  // run_n resets to 1 so the prescaler stays frozen until a real run request
  // has crossed both stages.
  localparam logic [c_in_w-1:0] c_sync_rst = c_in_w'(2);

  logic [c_in_w-1:0] r_sync1;
  logic [c_in_w-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= c_sync_rst;
      r_sync2 <= c_sync_rst;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = w_raw;
`endif

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic             w_run_n;
  logic             w_clear;

  assign {w_a, w_b, w_cin, w_run_n, w_clear} = w_in;

  // Adder, evaluated at WIDTH+1 bits so the top bit is the carry out
  logic [WIDTH:0] w_total;
  assign w_total = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_total[WIDTH-1:0];
      r_carry <= w_total[WIDTH];
    end
  end

  // Carry latch and rising-edge counter. The history register samples carry
  // even during clear, so a carry held high across clear is not re-counted.
  logic             r_carry_prev;
  logic             r_carry_latch;
  logic [CNT_W-1:0] r_carry_cnt;
  logic             w_carry_rise;

  assign w_carry_rise = r_carry & ~r_carry_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_carry_prev  <= 1'b0;
      r_carry_latch <= 1'b0;
      r_carry_cnt   <= '0;
    end else begin
      r_carry_prev <= r_carry;
      if (w_clear) begin
        r_carry_latch <= 1'b0;
        r_carry_cnt   <= '0;
      end else begin
        if (r_carry) begin
          r_carry_latch <= 1'b1;
        end
        if (w_carry_rise && (r_carry_cnt != c_cmax)) begin
          r_carry_cnt <= r_carry_cnt + 1'b1;
        end
      end
    end
  end

  // Prescaler: stopping holds the count so a resume loses no phase
  logic [c_pw-1:0]  r_pcnt;
  logic             r_tick;
  logic [CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt     <= '0;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
    end else if (w_clear) begin
      r_pcnt     <= '0;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      // tick is already registered, so it is counted even if run_n just rose
      if (r_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      if (!w_run_n) begin
        if (r_pcnt == c_pmax) begin
          r_pcnt <= '0;
          r_tick <= 1'b1;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign bus.sum         = r_sum;
  assign bus.carry       = r_carry;
  assign bus.carry_latch = r_carry_latch;
  assign bus.carry_cnt   = r_carry_cnt;
  assign bus.tick        = r_tick;
  assign bus.tick_cnt    = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adder_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder_timebase                                            |
// | Description : Self-checking bench for adder_timebase (WIDTH=4, DIV=6,      |
// |               CNT_W=2). Directed sequences followed by random stimulus,    |
// |               all compared against a behavioural model of the block.       |
// |               Honours INPUT_SYNC_EN by delaying model inputs 2 cycles.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adder_timebase;

  localparam int W   = 4;
  localparam int CW  = 2;
  localparam int DIV = 6;

  logic clk;
  logic reset_n;

  adder_timebase_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  adder_timebase #(
    .WIDTH  (W),
    .CLK_HZ (12),
    .TICK_HZ(2),
    .CNT_W  (CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: counts events since the last clear rather than
  // tracking a prescaler phase.
  typedef struct {
    int a;
    int b;
    int cin;
    int run_n;
    int clear;
  } stim_t;

  stim_t pipe[$];
  int m_sum, m_carry, m_hist, m_latch, m_edges, m_runs, m_tick, m_ticks;

  task automatic model_reset();
    stim_t idle;
    idle = '{a: 0, b: 0, cin: 0, run_n: 1, clear: 0};
    m_sum = 0; m_carry = 0; m_hist = 0; m_latch = 0;
    m_edges = 0; m_runs = 0; m_tick = 0; m_ticks = 0;
    pipe.delete();
    pipe.push_back(idle);
    pipe.push_back(idle);
  endtask

  task automatic model_clock(input stim_t s);
    stim_t e;
    int total, old_carry, old_tick;
`ifdef INPUT_SYNC_EN
    pipe.push_back(s);
    e = pipe.pop_front();
`else
    e = s;
`endif
    total     = e.a + e.b + e.cin;
    old_carry = m_carry;
    old_tick  = m_tick;
    if (e.clear != 0) begin
      m_latch = 0; m_edges = 0; m_runs = 0; m_tick = 0; m_ticks = 0;
    end else begin
      if (old_carry != 0) m_latch = 1;
      if (old_carry != 0 && m_hist == 0) m_edges++;
      m_ticks += old_tick;
      if (e.run_n == 0) begin
        m_runs++;
        m_tick = (m_runs % DIV == 0) ? 1 : 0;
      end else begin
        m_tick = 0;
      end
    end
    m_hist  = old_carry;
    m_sum   = total % (1 << W);
    m_carry = total / (1 << W);
  endtask

  task automatic check_all(input string pfx);
    check_eq({pfx, ".sum"},   32'(bus.sum),         32'(m_sum));
    check_eq({pfx, ".carry"}, 32'(bus.carry),       32'(m_carry));
    check_eq({pfx, ".latch"}, 32'(bus.carry_latch), 32'(m_latch));
    check_eq({pfx, ".ccnt"},  32'(bus.carry_cnt),   32'((m_edges > 3) ? 3 : m_edges));
    check_eq({pfx, ".tick"},  32'(bus.tick),        32'(m_tick));
    check_eq({pfx, ".tcnt"},  32'(bus.tick_cnt),    32'(m_ticks % (1 << CW)));
  endtask

  task automatic step(input string pfx, input int a, input int b, input int cin,
                      input int run_n, input int clear);
    stim_t s;
    s = '{a: a, b: b, cin: cin, run_n: run_n, clear: clear};
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.cin   = cin[0];
    bus.run_n = run_n[0];
    bus.clear = clear[0];
    @(posedge clk);
    model_clock(s);
    #1;
    check_all(pfx);
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock
  task automatic do_reset(input string pfx);
    #2 reset_n = 1'b0;
    #1;
    check_eq({pfx, ".rst_sum"},   32'(bus.sum),         0);
    check_eq({pfx, ".rst_carry"}, 32'(bus.carry),       0);
    check_eq({pfx, ".rst_latch"}, 32'(bus.carry_latch), 0);
    check_eq({pfx, ".rst_ccnt"},  32'(bus.carry_cnt),   0);
    check_eq({pfx, ".rst_tick"},  32'(bus.tick),        0);
    check_eq({pfx, ".rst_tcnt"},  32'(bus.tick_cnt),    0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.run_n = 1'b1;
    bus.clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 reset_n = 1'b1;

    // Adder and sticky latch
    step("t1a", 9, 8, 1, 1, 0);
    step("t1b", 1, 1, 0, 1, 0);
    step("t1c", 1, 1, 0, 1, 0);
`ifndef INPUT_SYNC_EN
    check_eq("t1.sum_direct",   32'(bus.sum),         2);
    check_eq("t1.latch_direct", 32'(bus.carry_latch), 1);
    check_eq("t1.ccnt_direct",  32'(bus.carry_cnt),   1);
`endif

    // Free-running timebase from reset
    do_reset("t2");
    for (int i = 1; i <= 30; i++) step("t2", 0, 0, 0, 0, 0);

    // Stop/resume keeps phase
    do_reset("t3");
    for (int i = 0; i < 3; i++)  step("t3run", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("t3stop", 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)  step("t3res", 0, 0, 0, 0, 0);

    // Carry-edge saturation and clear with carry held high
    do_reset("t4");
    for (int i = 0; i < 5; i++) begin
      step("t4hi", 15, 1, 0, 1, 0);
      step("t4lo", 0, 0, 0, 1, 0);
    end
    step("t4hold", 15, 1, 0, 1, 0);
    step("t4hold", 15, 1, 0, 1, 0);
    step("t4clr", 15, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step("t4post", 15, 1, 0, 1, 0);

    // Clear coincident with tick and carry rise, then async reset mid-count
    do_reset("t5");
    for (int i = 0; i < 4; i++) step("t5run", 0, 0, 0, 0, 0);
    step("t5carry", 15, 1, 0, 0, 0);
    step("t5clr", 15, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("t5post", 0, 0, 0, 0, 0);
    do_reset("t5mid");

    // Random traffic with occasional clears and one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rnd");
      step("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 24) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
